dct_seq_ctrl: RTL and testbench

- Sequencing controller for the two-pass 8x8 matrix-transform datapath.
- Pass 1 multiplies external memory rows by the C coefficient ROM and writes the products into the temp RAM.
- Pass 2 multiplies temp RAM contents by the C' coefficient ROM and writes the result back into temp, flagging each result to a downstream sink.
- Drives the datapath's counter enables, mux selects and temp write enable, and runs a req/ack handshake to the input memory.

---
 rtl/dct_pkg.sv | 41 ++++
 rtl/lat_wait.sv | 36 +++
 rtl/dct_seq_ctrl.sv | 114 +++++++++++
 tb/tb_dct_seq_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared types and constants for the 8x8 two-pass transform sequencer
package dct_pkg;

  localparam int IDX_W = 3;
  localparam int N     = 1 << IDX_W;

  localparam logic SEL_MEM  = 1'b0;
  localparam logic SEL_TEMP = 1'b1;
  localparam logic SEL_C    = 1'b0;
  localparam logic SEL_CP   = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_P1_FETCH,
    S_P1_WAIT,
    S_P1_WRITE,
    S_P1_ADV,
    S_P2_WAIT,
    S_P2_WRITE,
    S_P2_ADV,
    S_FIN
  } state_e;

  function automatic logic is_wait(input state_e s);
    return (s == S_P1_WAIT) || (s == S_P2_WAIT);
  endfunction

  function automatic logic is_adv(input state_e s);
    return (s == S_P1_ADV) || (s == S_P2_ADV);
  endfunction

  function automatic logic is_write(input state_e s);
    return (s == S_P1_WRITE) || (s == S_P2_WRITE);
  endfunction

  // Every pass-2 state, so the operand/coefficient selects stay put for the whole pass.
  function automatic logic is_p2(input state_e s);
    return (s == S_P2_WAIT) || (s == S_P2_WRITE) || (s == S_P2_ADV);
  endfunction

endpackage

// File: rtl/lat_wait.sv
// rtl/lat_wait.sv - loadable down-counter covering the RAM/ROM read latency
module lat_wait #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic expired_o
);

  // Loading RD_LAT-1 makes the wait state last exactly RD_LAT cycles, since 0 means expired.
  localparam logic [1:0] LOAD_VAL = 2'(RD_LAT - 1);

  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != 2'd0)) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == 2'd0);

endmodule

// File: rtl/dct_seq_ctrl.sv
// rtl/dct_seq_ctrl.sv - two-pass sequencer driving the transform datapath and input memory handshake
module dct_seq_ctrl #(
  parameter int IDX_W  = dct_pkg::IDX_W,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mem_ack,
  input  logic [IDX_W-1:0]     out_i,
  input  logic [IDX_W-1:0]     out_j,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_req,
  output logic [2*IDX_W-1:0]   mem_addr,
  output logic                 cnt_clr,
  output logic                 en_i,
  output logic                 en_j,
  output logic                 Wen_temp,
  output logic                 Smux1,
  output logic                 Smux2,
  output logic                 res_valid,
  output logic                 pass
);

  import dct_pkg::*;

  state_e state_q, state_d;

  logic busy_q, done_q, mem_req_q, en_i_q, en_j_q, wen_q;
  logic smux1_q, smux2_q, res_valid_q, pass_q;

  logic lat_load, lat_dec, lat_expired;
  logic last_col, last_elem;

  assign last_col  = (out_j == '1);
  assign last_elem = (out_i == '1) && last_col;

  // Reload on every entry into a wait state; ADV -> WAIT always crosses from a non-wait state.
  assign lat_load = is_wait(state_d) && !is_wait(state_q);
  assign lat_dec  = is_wait(state_q);

  lat_wait #(
    .RD_LAT (RD_LAT)
  ) u_lat_wait (
    .clk       (clk),
    .rst_n     (rst),
    .load_i    (lat_load),
    .dec_i     (lat_dec),
    .expired_o (lat_expired)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (start) state_d = S_P1_FETCH;
      S_P1_FETCH: if (mem_ack) state_d = S_P1_WAIT;
      S_P1_WAIT:  if (lat_expired) state_d = S_P1_WRITE;
      S_P1_WRITE: state_d = S_P1_ADV;
      S_P1_ADV:   state_d = last_elem ? S_P2_WAIT : S_P1_FETCH;
      S_P2_WAIT:  if (lat_expired) state_d = S_P2_WRITE;
      S_P2_WRITE: state_d = S_P2_ADV;
      S_P2_ADV:   state_d = last_elem ? S_FIN : S_P2_WAIT;
      S_FIN:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q after the edge.
  // out_j never moves between WRITE and ADV, so sampling it on the way into ADV is exact.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      en_i_q      <= 1'b0;
      en_j_q      <= 1'b0;
      wen_q       <= 1'b0;
      smux1_q     <= SEL_MEM;
      smux2_q     <= SEL_C;
      res_valid_q <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_FIN);
      mem_req_q   <= (state_d == S_P1_FETCH);
      en_j_q      <= is_adv(state_d);
      en_i_q      <= is_adv(state_d) && last_col;
      wen_q       <= is_write(state_d);
      res_valid_q <= (state_d == S_P2_WRITE);
      smux1_q     <= is_p2(state_d) ? SEL_TEMP : SEL_MEM;
      smux2_q     <= is_p2(state_d) ? SEL_CP : SEL_C;
      pass_q      <= is_p2(state_d);
    end
  end

  // The counter clear has to land in the start cycle so the first fetch sees (0,0).
  assign cnt_clr   = rst && (state_q == S_IDLE) && start;
  assign mem_addr  = mem_req_q ? {out_i, out_j} : '0;

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_req   = mem_req_q;
  assign en_i      = en_i_q;
  assign en_j      = en_j_q;
  assign Wen_temp  = wen_q;
  assign Smux1     = smux1_q;
  assign Smux2     = smux2_q;
  assign res_valid = res_valid_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_dct_seq_ctrl.sv
// tb/tb_dct_seq_ctrl.sv - directed bench for dct_seq_ctrl with a counter model of the datapath
module tb_dct_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic stall_en = 1'b0;
  logic mon_clr = 1'b1;

  always #5 clk = ~clk;

  logic       busy, done, mem_req, cnt_clr, en_i, en_j, Wen_temp, Smux1, Smux2, res_valid, pass;
  logic       mem_ack;
  logic [5:0] mem_addr;
  logic [2:0] dp_i = 3'd0;
  logic [2:0] dp_j = 3'd0;
  int         stall_cnt = 0;

  logic       busy2, done2, mem_req2, cnt_clr2, en_i2, en_j2, wen2, smux1_2, smux2_2, rv2, pass2;
  logic       mem_ack2;
  logic [5:0] mem_addr2;
  logic [2:0] dp2_i = 3'd0;
  logic [2:0] dp2_j = 3'd0;

  logic [16:0] outs1, outs2;
  assign outs1 = {busy, done, mem_req, cnt_clr, en_i, en_j, Wen_temp, Smux1, Smux2, res_valid, pass, mem_addr};
  assign outs2 = {busy2, done2, mem_req2, cnt_clr2, en_i2, en_j2, wen2, smux1_2, smux2_2, rv2, pass2, mem_addr2};

  assign mem_ack  = mem_req && !(stall_en && (mem_addr == 6'd21) && (stall_cnt < 3));
  assign mem_ack2 = mem_req2;

  dct_seq_ctrl #(.IDX_W(3), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_ack(mem_ack), .out_i(dp_i), .out_j(dp_j),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr), .cnt_clr(cnt_clr),
    .en_i(en_i), .en_j(en_j), .Wen_temp(Wen_temp), .Smux1(Smux1), .Smux2(Smux2),
    .res_valid(res_valid), .pass(pass)
  );

  dct_seq_ctrl #(.IDX_W(3), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mem_ack(mem_ack2), .out_i(dp2_i), .out_j(dp2_j),
    .busy(busy2), .done(done2), .mem_req(mem_req2), .mem_addr(mem_addr2), .cnt_clr(cnt_clr2),
    .en_i(en_i2), .en_j(en_j2), .Wen_temp(wen2), .Smux1(smux1_2), .Smux2(smux2_2),
    .res_valid(rv2), .pass(pass2)
  );

  // Datapath index counters and the ack-stall source.
  always @(posedge clk) begin
    if (cnt_clr) begin
      dp_i <= 3'd0;
      dp_j <= 3'd0;
    end else begin
      if (en_j) dp_j <= dp_j + 3'd1;
      if (en_i) dp_i <= dp_i + 3'd1;
    end
    if (cnt_clr2) begin
      dp2_i <= 3'd0;
      dp2_j <= 3'd0;
    end else begin
      if (en_j2) dp2_j <= dp2_j + 3'd1;
      if (en_i2) dp2_i <= dp2_i + 3'd1;
    end
    if (!stall_en) stall_cnt <= 0;
    else if (mem_req && (mem_addr == 6'd21) && (stall_cnt < 3)) stall_cnt <= stall_cnt + 1;
  end

  int wen_p1, wen_p2, rv_cnt, rv_bad, eni_p1, eni_p2, eni_bad, enj_cnt, done_cnt;
  int overlap, addr_bad, acc_cnt, smux_enj, smux_prev, smux_both;
  logic smux_seen, prev_enj;
  logic [5:0] exp_addr;

  always @(negedge clk) begin
    if (mon_clr) begin
      wen_p1 = 0; wen_p2 = 0; rv_cnt = 0; rv_bad = 0; eni_p1 = 0; eni_p2 = 0; eni_bad = 0;
      enj_cnt = 0; done_cnt = 0; overlap = 0; addr_bad = 0; acc_cnt = 0; exp_addr = 6'd0;
      smux_seen = 1'b0; smux_enj = -1; smux_prev = -1; smux_both = -1; prev_enj = 1'b0;
    end else begin
      if (Smux1 && !smux_seen) begin
        smux_seen = 1'b1;
        smux_enj  = enj_cnt;
        smux_prev = int'(prev_enj);
        smux_both = int'(Smux2 && pass);
      end
      if (Wen_temp) begin
        if (pass) wen_p2++; else wen_p1++;
      end
      if (res_valid) begin
        rv_cnt++;
        if (!(Wen_temp && pass)) rv_bad++;
      end
      if (en_i) begin
        if (pass) eni_p2++; else eni_p1++;
        if (!(en_j && dp_j == 3'd7)) eni_bad++;
      end
      if (en_j) enj_cnt++;
      if (done) done_cnt++;
      if (Wen_temp && mem_req) overlap++;
      if (mem_req && mem_ack) begin
        if (mem_addr != exp_addr) addr_bad++;
        exp_addr = exp_addr + 6'd1;
        acc_cnt++;
      end
      prev_enj = en_j;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one frame on dut from a posedge+2 phase; cycle 1 is the start cycle.
  task automatic frame(input int ign_a, input int ign_b, input int abort_at,
                       output int done_cyc, output int clr_seen, output int busy_gap,
                       output logic [16:0] abort_outs);
    int cyc;
    mon_clr = 1'b1;
    @(posedge clk); #2;
    mon_clr = 1'b0;
    done_cyc = -1;
    busy_gap = 0;
    abort_outs = '1;
    start = 1'b1;
    #1 clr_seen = int'(cnt_clr);
    cyc = 1;
    while (cyc < 1000) begin
      @(posedge clk); #2;
      cyc++;
      start = (cyc == ign_a) || (cyc == ign_b);
      if (cyc == abort_at) begin
        rst = 1'b0;
        #1 abort_outs = outs1;
        start = 1'b0;
        return;
      end
      if (!busy) busy_gap++;
      if (done) begin
        done_cyc = cyc;
        start = 1'b0;
        return;
      end
    end
    start = 1'b0;
  endtask

  int dc, clr, gap, cyc2;
  logic [16:0] aouts;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outs", int'(outs1), 0);
    chk("reset_outs_lat2", int'(outs2), 0);
    rst = 1'b1;
    @(posedge clk); #2;
    chk("idle_outs", int'(outs1), 0);

    frame(0, 0, 0, dc, clr, gap, aouts);
    chk("nom_cnt_clr", clr, 1);
    chk("nom_done_cycle", dc, 450);
    chk("nom_busy_gap", gap, 0);
    @(posedge clk); #2;
    chk("nom_idle_after", int'({busy, done}), 0);
    chk("nom_wen_p1", wen_p1, 64);
    chk("nom_wen_p2", wen_p2, 64);
    chk("nom_res_valid", rv_cnt, 64);
    chk("nom_rv_alone", rv_bad, 0);
    chk("nom_accepts", acc_cnt, 64);
    chk("nom_addr_order", addr_bad, 0);
    chk("nom_done_pulses", done_cnt, 1);
    chk("wrap_eni_p1", eni_p1, 8);
    chk("wrap_eni_p2", eni_p2, 8);
    chk("wrap_eni_col7", eni_bad, 0);
    chk("wrap_smux_after_adv64", smux_enj, 64);
    chk("wrap_smux_prev_adv", smux_prev, 1);
    chk("wrap_smux_both", smux_both, 1);

    stall_en = 1'b1;
    frame(0, 0, 0, dc, clr, gap, aouts);
    chk("stall_done_cycle", dc, 453);
    @(posedge clk); #2;
    stall_en = 1'b0;
    chk("stall_no_wen", overlap, 0);
    chk("stall_wen_p1", wen_p1, 64);
    chk("stall_accepts", acc_cnt, 64);
    chk("stall_addr_order", addr_bad, 0);

    frame(10, 300, 0, dc, clr, gap, aouts);
    chk("bstart_done_cycle", dc, 450);
    chk("bstart_busy_gap", gap, 0);
    repeat (20) @(posedge clk);
    #2;
    chk("bstart_done_pulses", done_cnt, 1);
    chk("bstart_idle", int'(busy), 0);

    frame(0, 0, 319, dc, clr, gap, aouts);
    chk("rst_async_outs", int'(aouts), 0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1;
    chk("rst_no_done", done_cnt, 0);
    @(posedge clk); #2;
    chk("rst_idle", int'(outs1), 0);
    frame(0, 0, 0, dc, clr, gap, aouts);
    chk("rst_new_cnt_clr", clr, 1);
    chk("rst_new_done_cycle", dc, 450);
    @(posedge clk); #2;
    chk("rst_new_addr_order", addr_bad, 0);
    chk("rst_new_accepts", acc_cnt, 64);
    chk("rst_new_wen_p2", wen_p2, 64);

    start2 = 1'b1;
    #1 chk("lat2_cnt_clr", int'(cnt_clr2), 1);
    cyc2 = 1;
    dc = -1;
    while (cyc2 < 1000) begin
      @(posedge clk); #2;
      start2 = 1'b0;
      cyc2++;
      if (done2) begin
        dc = cyc2;
        break;
      end
    end
    chk("lat2_done_cycle", dc, 578);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
